// File: rtl/pazen_lane_register_bank.sv
// rtl/pazen_lane_register_bank.sv - dual-port 64-bit x DEPTH lane-writable bank with clear sequencer
// Optional lane parity via PAZEN_BANK_PARITY_EN.
module pazen_lane_register_bank #(
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CSA,
  input  logic          CSB,
  input  logic          WEAN,
  input  logic          WEBN,
  input  logic [AW-1:0] A_w,
  input  logic [AW-1:0] B_w,
  input  logic [3:0]    MUXA,
  input  logic [3:0]    MUXB,
  input  logic [63:0]   DIA_T_w,
  input  logic [63:0]   DIB_T_w,
  input  logic          clr,
`ifdef PAZEN_BANK_PARITY_EN
  input  logic          par_inj,
  output logic [3:0]    perr_a,
  output logic [3:0]    perr_b,
`endif
  output logic [63:0]   DOA,
  output logic [63:0]   DOB,
  output logic          busy,
  output logic [1:0]    addr_err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [63:0]   mem [DEPTH];
`ifdef PAZEN_BANK_PARITY_EN
  logic [3:0]    par [DEPTH];
`endif

  logic in_range_a, in_range_b;
  logic we_a, we_b, re_a, re_b;

  assign in_range_a = int'(A_w) < DEPTH;
  assign in_range_b = int'(B_w) < DEPTH;

  // Port traffic is only honoured while idle; the clear sequencer owns the array otherwise.
  assign we_a = CSA && !WEAN && in_range_a && (state == IDLE);
  assign we_b = CSB && !WEBN && in_range_b && (state == IDLE);
  assign re_a = CSA &&  WEAN && (state == IDLE);
  assign re_b = CSB &&  WEBN && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      busy     <= 1'b0;
      DOA      <= '0;
      DOB      <= '0;
      addr_err <= '0;
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
`ifdef PAZEN_BANK_PARITY_EN
        par[w] <= '0;
`endif
      end
`ifdef PAZEN_BANK_PARITY_EN
      perr_a <= '0;
      perr_b <= '0;
`endif
    end else begin
      addr_err <= {CSB && !in_range_b, CSA && !in_range_a};

      // Reads sample the array before this edge's writes land, giving read-first behaviour.
      if (re_a) begin
        DOA <= in_range_a ? mem[A_w] : '0;
`ifdef PAZEN_BANK_PARITY_EN
        for (int i = 0; i < 4; i++)
          perr_a[i] <= in_range_a && (par[A_w][i] != (^mem[A_w][16*i +: 16]));
`endif
      end
      if (re_b) begin
        DOB <= in_range_b ? mem[B_w] : '0;
`ifdef PAZEN_BANK_PARITY_EN
        for (int i = 0; i < 4; i++)
          perr_b[i] <= in_range_b && (par[B_w][i] != (^mem[B_w][16*i +: 16]));
`endif
      end

      // Port B is applied first so port A overrides it on a shared lane.
      for (int i = 0; i < 4; i++) begin
        if (we_b && MUXB[i]) begin
          mem[B_w][16*i +: 16] <= DIB_T_w[16*i +: 16];
`ifdef PAZEN_BANK_PARITY_EN
          par[B_w][i] <= (^DIB_T_w[16*i +: 16]) ^ par_inj;
`endif
        end
        if (we_a && MUXA[i]) begin
          mem[A_w][16*i +: 16] <= DIA_T_w[16*i +: 16];
`ifdef PAZEN_BANK_PARITY_EN
          par[A_w][i] <= (^DIA_T_w[16*i +: 16]) ^ par_inj;
`endif
        end
      end

      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
`ifdef PAZEN_BANK_PARITY_EN
          par[ptr] <= '0;
`endif
          if (ptr == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pazen_lane_register_bank.md
Name: pazen_lane_register_bank

Overview:
- Dual-port storage bank that answers the pazen memory controller's steering outputs: one 64-bit-wide bank of DEPTH words with four 16-bit lanes per word.
- Accepts the controller's bank-local word address, one-hot lane select, lane-positioned 64-bit write data and bank chip select; returns registered 64-bit read words for the controller to lane-extract.
- Seven instances, one per choose_reg bit, form the full 256x16 SISP memory.
- Also contains a clear sequencer that zeroes the bank on request.

Parameters:
- DEPTH, 10, number of 64-bit words; valid word addresses are 0..DEPTH-1.
- AW, 4, word address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- CSA, CSB  in  1  bank select per port (choose_reg_A_w/B_w bit); active high.
- WEAN, WEBN  in  1  write enable per port; active low; 1 = read.
- A_w, B_w  in  AW  bank-local word address.
- MUXA, MUXB  in  4  one-hot lane select; bit i selects bits [16i+15:16i].
- DIA_T_w, DIB_T_w  in  64  lane-positioned write data.
- clr  in  1  single-cycle pulse: zero all words.
- DOA, DOB  out  64  registered read data.
- busy  out  1  clear sequence in progress.
- addr_err  out  2  one-cycle pulse; bit0 = port A, bit1 = port B; access with address >= DEPTH.

Behaviour:
- Reset (reset=0, async): all words = 0, DOA = DOB = 0, busy = 0, addr_err = 0, FSM = IDLE.
- Write, port A: CSA=1, WEAN=0, A_w<DEPTH, FSM=IDLE.
  - At the clock edge, each lane i with MUXA[i]=1 takes DIA_T_w[16i+15:16i].
  - Unselected lanes are unchanged.
  - MUXA=0000 writes nothing.
  - More than one MUX bit set: all selected lanes are written. No one-hot check.
  - DOA holds its value during a write.
- Write, port B: identical to port A using the B signals.
- Read, port A: CSA=1, WEAN=1, A_w<DEPTH, FSM=IDLE.
  - DOA = mem[A_w] at the clock edge, i.e. 1-cycle latency.
  - MUXA is ignored; the controller does lane extraction.
- Read, port B: identical to port A using the B signals.
- Idle port: CS=0 → DO holds its previous value.
- Read-first: a read and a write to the same word in the same cycle (either port) returns the pre-write contents; new data is visible on the next read.
- Dual-write collision:
  - Same word, same lane: port A data wins.
  - Same word, disjoint lanes: both writes apply.
- Out-of-range address (>= DEPTH) with CS=1:
  - Write is dropped.
  - Read loads DO = 0.
  - The corresponding addr_err bit pulses high for 1 cycle.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR on clr=1. Clear pointer = 0; busy=1 from the next cycle.
  - CLEAR: writes mem[ptr]=0 each cycle and increments ptr. After writing ptr=DEPTH-1, returns to IDLE; busy=0 in the following cycle.
  - Clear takes exactly DEPTH cycles.
  - clr while already in CLEAR: ignored, no restart.
- During CLEAR:
  - All port writes are dropped.
  - Port reads do not update DO; DO holds.
  - addr_err is still generated.
- Reset asserted mid-CLEAR: immediate return to IDLE, all words 0.
- Pointer width: AW bits. No wrap: termination is on ptr==DEPTH-1.

Optional Feature:
- Macro PAZEN_BANK_PARITY_EN.
- Defined:
  - One even-parity bit is stored per lane, written alongside that lane's data and cleared to 0 by reset and by CLEAR.
  - Added outputs perr_a, perr_b [3:0]: registered with DO, one bit per lane, high when the stored parity of the read word mismatches the recomputed parity.
  - Added input par_inj (1): when high during a write, the selected lanes' stored parity bits are inverted, for test.
- Not defined: no parity storage and no perr/par_inj ports; all other behaviour identical.

Test Plan:
- Reset, then port A reads words 0..9 → DOA=0 one cycle after each read; addr_err=00.
- A writes word 3, MUXA=0010, DIA_T_w=0x0000_0000_BEEF_0000; then B writes word 3, MUXB=1000, DIB_T_w=0x1234_0000_0000_0000; then A reads word 3 → DOA=0x1234_0000_BEEF_0000.
- Same cycle, A and B write word 5 lane 0 with 0xAAAA / 0x5555 → read gives lane0=0xAAAA. Same cycle, A reads word 5 while B writes 0xFFFF to lane1 → DOA shows old lane1; next read shows 0xFFFF.
- Fill all words with 0xFFFF…; pulse clr → busy=1 for exactly 10 cycles; a port-A write issued mid-clear is dropped; afterwards every word reads 0.
- A reads address 12 → DOA=0 and addr_err=01 for 1 cycle; B writes address 15 → no word changes and addr_err=10.
- With PAZEN_BANK_PARITY_EN: write lane2=0x0001 with par_inj=1, then read → perr_a=0100. Rewrite with par_inj=0, then read → perr_a=0000.
